// File: rtl/e203_ifu_flush_rcv.sv
// IFU flush/redirect receiver: drains stale fetch responses after a flush and issues one redirected fetch.
// Optional E203_FLUSH_BYPASS_EN issues the redirect in the ack cycle when nothing is outstanding.
module e203_ifu_flush_rcv #(
    parameter int PC_SIZE  = 32,
    parameter int OUTS_MAX = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_req,
    input  logic [PC_SIZE-1:0] flush_add_op1,
    input  logic [PC_SIZE-1:0] flush_add_op2,
    output logic               flush_ack,
    input  logic               seq_req_valid,
    input  logic [PC_SIZE-1:0] seq_req_pc,
    output logic               seq_req_ready,
    output logic               ifu_req_valid,
    output logic [PC_SIZE-1:0] ifu_req_pc,
    input  logic               ifu_req_ready,
    input  logic               ifu_rsp_valid,
    output logic               ifu_rsp_ready,
    output logic               o_rsp_valid,
    input  logic               o_rsp_ready,
    output logic               redir_ena,
    output logic [PC_SIZE-1:0] redir_pc
);

    localparam int CW = $clog2(OUTS_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(OUTS_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PC_SIZE-1:0] tgt_q, tgt_d;

    logic [PC_SIZE-1:0] flush_pc;
    logic               cnt_full;
    logic               cnt_zero;
    logic               req_hs;
    logic               rsp_hs;

    assign flush_pc = flush_add_op1 + flush_add_op2;
    assign cnt_full = (cnt_q == CNT_MAX);
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        flush_ack     = flush_req;
        seq_req_ready = 1'b0;
        ifu_req_valid = 1'b0;
        ifu_req_pc    = seq_req_pc;
        ifu_rsp_ready = 1'b0;
        o_rsp_valid   = 1'b0;
        redir_ena     = 1'b0;
        redir_pc      = tgt_q;
        state_d       = state_q;
        tgt_d         = tgt_q;
        cnt_d         = cnt_q;

        case (state_q)
            IDLE: begin
                ifu_req_valid = seq_req_valid & ~flush_req & ~cnt_full;
                seq_req_ready = ifu_req_ready & ~flush_req & ~cnt_full;
                o_rsp_valid   = ifu_rsp_valid;
                ifu_rsp_ready = o_rsp_ready;
`ifdef E203_FLUSH_BYPASS_EN
                if (flush_req && cnt_zero) begin
                    ifu_req_valid = 1'b1;
                    ifu_req_pc    = flush_pc;
                    redir_ena     = ifu_req_ready;
                    redir_pc      = flush_pc;
                end
`endif
            end
            DRAIN: begin
                ifu_rsp_ready = 1'b1;
            end
            REDIR: begin
                // A same-cycle flush wins over the pending redirect request.
                ifu_req_valid = ~flush_req;
                ifu_req_pc    = tgt_q;
                redir_ena     = ~flush_req & ifu_req_ready;
            end
            default: ;
        endcase

        req_hs = ifu_req_valid & ifu_req_ready;
        rsp_hs = ifu_rsp_valid & ifu_rsp_ready;
        if (req_hs && !rsp_hs) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!req_hs && rsp_hs) begin
            cnt_d = cnt_q - CW'(1);
        end

        if (flush_req) begin
            tgt_d   = flush_pc;
            state_d = (cnt_d != '0) ? DRAIN : REDIR;
            if (state_q == IDLE && redir_ena) begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                DRAIN:   if (cnt_d == '0) state_d = REDIR;
                REDIR:   if (redir_ena)   state_d = IDLE;
                IDLE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = cnt_zero;

endmodule
